// File: rtl/systolic_pkg.sv
//==============================================================================
// Module : systolic_pkg
// Brief  : Shared types, default sizes and the skew-lane helper for the feeder.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package systolic_pkg;

  localparam int DEFAULT_DATAWIDTH = 16;
  localparam int DEFAULT_N_SIZE    = 5;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } feeder_state_e;

  // idx is wide enough for the largest legal matrix (8x8)
  typedef struct packed {
    logic       in_range;
    logic [2:0] idx;
  } lane_sel_t;

  function automatic lane_sel_t lane_sel(input int t, input int lane, input int n);
    lane_sel_t r;
    int        k;
    k          = t - lane;
    r.in_range = (k >= 0) && (k < n);
    r.idx      = r.in_range ? k[2:0] : 3'd0;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_feeder_if.sv
//==============================================================================
// Module : systolic_feeder_if
// Brief  : Valid/ready matrix-beat stream carrying one A row and one B column.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface systolic_feeder_if #(
  parameter int DATAWIDTH = 16,
  parameter int N_SIZE    = 5
);
  logic                        s_valid;
  logic                        s_ready;
  logic [N_SIZE*DATAWIDTH-1:0] s_row_a;
  logic [N_SIZE*DATAWIDTH-1:0] s_col_b;

  modport master (output s_valid, output s_row_a, output s_col_b, input s_ready);
  modport slave  (input s_valid, input s_row_a, input s_col_b, output s_ready);
endinterface

`default_nettype wire

// File: rtl/systolic_feeder_bank.sv
//==============================================================================
// Module : systolic_feeder_bank
// Brief  : One NxN A bank and one NxN B bank; beat write port, skewed read.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module systolic_feeder_bank
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int N_SIZE    = DEFAULT_N_SIZE,
  parameter int TW        = $clog2(2*N_SIZE)
) (
  input  wire logic                        clk,
  input  wire logic                        rst,
  input  wire logic                        wr_en,
  input  wire logic [$clog2(N_SIZE)-1:0]   wr_idx,
  input  wire logic [N_SIZE*DATAWIDTH-1:0] wr_row,
  input  wire logic [N_SIZE*DATAWIDTH-1:0] wr_col,
  input  wire logic [TW-1:0]               rd_t,
  output logic      [N_SIZE*DATAWIDTH-1:0] rd_a,
  output logic      [N_SIZE*DATAWIDTH-1:0] rd_b
);

  localparam int IW = $clog2(N_SIZE);

  logic [DATAWIDTH-1:0] a_q [N_SIZE][N_SIZE];
  logic [DATAWIDTH-1:0] a_d [N_SIZE][N_SIZE];
  logic [DATAWIDTH-1:0] b_q [N_SIZE][N_SIZE];
  logic [DATAWIDTH-1:0] b_d [N_SIZE][N_SIZE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N_SIZE; r++) begin
        for (int m = 0; m < N_SIZE; m++) begin
          a_q[r][m] <= '0;
          b_q[r][m] <= '0;
        end
      end
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  // Beat k carries row k of A and column k of B.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    for (int r = 0; r < N_SIZE; r++) begin
      for (int m = 0; m < N_SIZE; m++) begin
        if (wr_en && (wr_idx == IW'(r))) begin
          a_d[r][m] = wr_row[m*DATAWIDTH +: DATAWIDTH];
          b_d[m][r] = wr_col[m*DATAWIDTH +: DATAWIDTH];
        end
      end
    end
  end

  always_comb begin
    lane_sel_t ls;
    ls   = '0;
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < N_SIZE; i++) begin
      ls = lane_sel(int'(rd_t), i, N_SIZE);
      for (int k = 0; k < N_SIZE; k++) begin
        if (ls.in_range && (ls.idx == 3'(k))) begin
          rd_a[i*DATAWIDTH +: DATAWIDTH] = a_q[i][k];
          rd_b[i*DATAWIDTH +: DATAWIDTH] = b_q[k][i];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/systolic_feeder.sv
//==============================================================================
// Module : systolic_feeder
// Brief  : Loads A/B matrices, replays them as a skewed wavefront, then drains.
//          SYSTOLIC_FEEDER_DBUF_EN selects ping/pong banks with overlapped load.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH    = DEFAULT_DATAWIDTH,
  parameter int N_SIZE       = DEFAULT_N_SIZE,
  parameter int DRAIN_CYCLES = N_SIZE + 2
) (
  input  wire logic                        clk,
  input  wire logic                        rst,
  systolic_feeder_if.slave                 s,
  output logic                             arr_valid,
  output logic      [N_SIZE*DATAWIDTH-1:0] arr_a,
  output logic      [N_SIZE*DATAWIDTH-1:0] arr_b,
  output logic                             busy
);

  localparam int LW  = N_SIZE * DATAWIDTH;
  localparam int TW  = $clog2(2*N_SIZE);
  localparam int DCW = $clog2(DRAIN_CYCLES+1);
  localparam int FW  = $clog2(N_SIZE+1);
  localparam int IW  = $clog2(N_SIZE);
  localparam logic [TW-1:0]  T_LAST = TW'(2*N_SIZE-2);
  localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN_CYCLES-1);
  localparam logic [FW-1:0]  F_LAST = FW'(N_SIZE-1);
  localparam logic [FW-1:0]  F_FULL = FW'(N_SIZE);
`ifdef SYSTOLIC_FEEDER_DBUF_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  feeder_state_e state_q, state_d;
  logic [TW-1:0]  t_q, t_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic [FW-1:0]  fill_q, fill_d, fill_inc;
  logic           arr_valid_q, arr_valid_d;
  logic [LW-1:0]  arr_a_q, arr_a_d, arr_b_q, arr_b_d;
  logic           accept;
  logic [NBANK-1:0] bank_we;
  logic [LW-1:0]  bank_a [NBANK];
  logic [LW-1:0]  bank_b [NBANK];
  logic [LW-1:0]  sel_a, sel_b;

  assign accept   = s.s_valid && s.s_ready;
  assign fill_inc = fill_q + FW'(accept);

`ifdef SYSTOLIC_FEEDER_DBUF_EN
  logic cur_q, cur_d, wbank;
  // In LOAD the active bank fills; otherwise the idle bank prefetches.
  assign wbank   = (state_q == LOAD) ? cur_q : ~cur_q;
  assign bank_we = {accept && wbank, accept && !wbank};
  assign sel_a   = bank_a[cur_d];
  assign sel_b   = bank_b[cur_d];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_q <= 1'b0;
    else     cur_q <= cur_d;
  end
`else
  assign bank_we = accept;
  assign sel_a   = bank_a[0];
  assign sel_b   = bank_b[0];
`endif

  for (genvar g = 0; g < NBANK; g++) begin : g_bank
    systolic_feeder_bank #(
      .DATAWIDTH(DATAWIDTH), .N_SIZE(N_SIZE), .TW(TW)
    ) u_bank (
      .clk(clk), .rst(rst), .wr_en(bank_we[g]), .wr_idx(fill_q[IW-1:0]),
      .wr_row(s.s_row_a), .wr_col(s.s_col_b), .rd_t(t_d),
      .rd_a(bank_a[g]), .rd_b(bank_b[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      t_q         <= '0;
      drain_q     <= '0;
      fill_q      <= '0;
      arr_valid_q <= 1'b0;
      arr_a_q     <= '0;
      arr_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      drain_q     <= drain_d;
      fill_q      <= fill_d;
      arr_valid_q <= arr_valid_d;
      arr_a_q     <= arr_a_d;
      arr_b_q     <= arr_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    drain_d = drain_q;
    fill_d  = fill_q;
`ifdef SYSTOLIC_FEEDER_DBUF_EN
    cur_d   = cur_q;
`endif
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          if (fill_q == F_LAST) begin
            state_d = FEED;
            t_d     = '0;
            fill_d  = '0;
          end else begin
            fill_d  = fill_inc;
          end
        end
      end
      FEED: begin
        fill_d = fill_inc;
        if (t_q == T_LAST) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      DRAIN: begin
        fill_d = fill_inc;
        if (drain_q == D_LAST) begin
`ifdef SYSTOLIC_FEEDER_DBUF_EN
          cur_d = ~cur_q;
          if (fill_inc == F_FULL) begin
            state_d = FEED;
            t_d     = '0;
            fill_d  = '0;
          end else begin
            state_d = LOAD;
          end
`else
          state_d = LOAD;
          fill_d  = '0;
`endif
        end else begin
          drain_d = drain_q + DCW'(1);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Banks are read at the step the output register will present next cycle,
  // so the first wavefront step leaves on the edge of the last beat.
  always_comb begin
    arr_valid_d = (state_d == FEED);
    arr_a_d     = arr_valid_d ? sel_a : '0;
    arr_b_d     = arr_valid_d ? sel_b : '0;
`ifdef SYSTOLIC_FEEDER_DBUF_EN
    s.s_ready   = (state_q == LOAD) || (fill_q != F_FULL);
`else
    s.s_ready   = (state_q == LOAD);
`endif
    busy        = (state_q != LOAD);
  end

  assign arr_valid = arr_valid_q;
  assign arr_a     = arr_a_q;
  assign arr_b     = arr_b_q;

endmodule

`default_nettype wire

// File: tb/tb_systolic_feeder.sv
//==============================================================================
// Module : tb_systolic_feeder
// Brief  : Directed self-checking bench for systolic_feeder (N=2, DW=16).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_systolic_feeder;

  localparam int DW = 16;
  localparam int N  = 2;
  localparam int LW = N * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arr_valid, busy;
  logic [LW-1:0] arr_a, arr_b;

  always #5 clk = ~clk;

  systolic_feeder_if #(.DATAWIDTH(DW), .N_SIZE(N)) sif ();

  systolic_feeder #(.DATAWIDTH(DW), .N_SIZE(N)) dut (
    .clk(clk), .rst(rst), .s(sif),
    .arr_valid(arr_valid), .arr_a(arr_a), .arr_b(arr_b), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Lane words are {lane1, lane0}; index = feed step t.
  logic [LW-1:0] m1_a [3] = '{32'h0000_0001, 32'h0003_0002, 32'h0004_0000};
  logic [LW-1:0] m1_b [3] = '{32'h0000_0005, 32'h0006_0007, 32'h0008_0000};
  logic [LW-1:0] m2_a [3] = '{32'h0000_0009, 32'h000B_000A, 32'h000C_0000};
  logic [LW-1:0] m2_b [3] = '{32'h0000_000D, 32'h000E_000F, 32'h0010_0000};

  logic          cap_v [4];
  logic [LW-1:0] cap_a [4];
  logic [LW-1:0] cap_b [4];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [LW-1:0] ra, input logic [LW-1:0] cb);
    sif.s_valid = v;
    sif.s_row_a = ra;
    sif.s_col_b = cb;
  endtask

  task automatic do_reset;
    drive(1'b0, '0, '0);
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Records FEED t=0..2 and the first DRAIN cycle, starting at the current cycle.
  task automatic capture;
    for (int i = 0; i < 4; i++) begin
      cap_v[i] = arr_valid;
      cap_a[i] = arr_a;
      cap_b[i] = arr_b;
      if (i < 3) tick;
    end
  endtask

  task automatic load_m1;
    drive(1'b1, 32'h0002_0001, 32'h0007_0005);
    tick;
    drive(1'b1, 32'h0004_0003, 32'h0008_0006);
    tick;
    drive(1'b0, '0, '0);
  endtask

  task automatic load_m2;
    drive(1'b1, 32'h000A_0009, 32'h000F_000D);
    tick;
    drive(1'b1, 32'h000C_000B, 32'h0010_000E);
    tick;
    drive(1'b0, '0, '0);
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++;
    if (sif.s_ready !== 1'b1 || arr_valid !== 1'b0 || busy !== 1'b0 ||
        arr_a !== '0 || arr_b !== '0) begin
      n_bad++;
      $display("FAIL reset_state: ready=%b valid=%b busy=%b a=%h b=%h, required 1 0 0 0 0",
               sif.s_ready, arr_valid, busy, arr_a, arr_b);
    end
  endtask

  task automatic test_basic_feed;
    int c_mat [N][N];
    int c_exp [N][N];
    int av, bv;
    c_exp = '{'{19, 22}, '{43, 50}};
    do_reset;
    drive(1'b1, 32'h0002_0001, 32'h0007_0005);
    tick;
    n_cmp++;
    if (sif.s_ready !== 1'b1 || arr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_midload: ready=%b valid=%b, required 1 0", sif.s_ready, arr_valid);
    end
    drive(1'b1, 32'h0004_0003, 32'h0008_0006);
    tick;
    drive(1'b0, '0, '0);
    capture;
    for (int t = 0; t < 3; t++) begin
      n_cmp++;
      if (cap_v[t] !== 1'b1 || cap_a[t] !== m1_a[t] || cap_b[t] !== m1_b[t]) begin
        n_bad++;
        $display("FAIL basic_t%0d: v=%b a=%h b=%h, required 1 %h %h",
                 t, cap_v[t], cap_a[t], cap_b[t], m1_a[t], m1_b[t]);
      end
    end
    n_cmp++;
    if (cap_v[3] !== 1'b0 || cap_a[3] !== '0 || cap_b[3] !== '0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_drain0: v=%b a=%h b=%h busy=%b, required 0 0 0 1",
               cap_v[3], cap_a[3], cap_b[3], busy);
    end
    // Downstream array: PE(i,j) sees lane a_i delayed j and lane b_j delayed i.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        c_mat[i][j] = 0;
        for (int c = 0; c < 6; c++) begin
          av = ((c - j) >= 0 && (c - j) < 3) ? int'($signed(cap_a[c-j][i*DW +: DW])) : 0;
          bv = ((c - i) >= 0 && (c - i) < 3) ? int'($signed(cap_b[c-i][j*DW +: DW])) : 0;
          c_mat[i][j] += av * bv;
        end
        n_cmp++;
        if (c_mat[i][j] != c_exp[i][j]) begin
          n_bad++;
          $display("FAIL basic_C%0d%0d: got %0d, required %0d", i, j, c_mat[i][j], c_exp[i][j]);
        end
      end
    end
  endtask

  task automatic test_handshake;
    int lowcnt;
    do_reset;
    drive(1'b1, 32'h000B_000A, 32'h0015_0014);
    tick;
    drive(1'b0, 32'h0063_0063, 32'h0063_0063);
    tick;
    n_cmp++;
    if (sif.s_ready !== 1'b1 || arr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hs_gap: ready=%b valid=%b, required 1 0", sif.s_ready, arr_valid);
    end
    drive(1'b1, 32'h000D_000C, 32'h0017_0016);
    tick;
    drive(1'b0, '0, '0);
    capture;
    n_cmp++;
    if (cap_v[0] !== 1'b1 || cap_a[0] !== 32'h0000_000A || cap_b[0] !== 32'h0000_0014) begin
      n_bad++;
      $display("FAIL hs_t0: v=%b a=%h b=%h, required 1 0000000a 00000014", cap_v[0], cap_a[0], cap_b[0]);
    end
    n_cmp++;
    if (cap_a[1] !== 32'h000C_000B || cap_b[1] !== 32'h0016_0015) begin
      n_bad++;
      $display("FAIL hs_t1: a=%h b=%h, required 000c000b 00160015", cap_a[1], cap_b[1]);
    end
    n_cmp++;
    if (cap_a[2] !== 32'h000D_0000 || cap_b[2] !== 32'h0017_0000) begin
      n_bad++;
      $display("FAIL hs_t2: a=%h b=%h, required 000d0000 00170000", cap_a[2], cap_b[2]);
    end
`ifndef SYSTOLIC_FEEDER_DBUF_EN
    // Three FEED cycles already seen; now at DRAIN d=0.
    lowcnt = 3;
    for (int k = 0; k < 50; k++) begin
      if (sif.s_ready === 1'b1) break;
      lowcnt++;
      tick;
    end
    n_cmp++;
    if (lowcnt != 3 + (N + 2)) begin
      n_bad++;
      $display("FAIL hs_ready_low: got %0d cycles, required %0d", lowcnt, 3 + N + 2);
    end
`endif
  endtask

  task automatic test_reset_midfeed;
    do_reset;
    load_m1;
    tick;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (arr_valid !== 1'b0 || arr_a !== '0 || arr_b !== '0 || sif.s_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_async: valid=%b a=%h b=%h ready=%b busy=%b, required 0 0 0 1 0",
               arr_valid, arr_a, arr_b, sif.s_ready, busy);
    end
    tick;
    rst = 1'b0;
    load_m2;
    capture;
    for (int t = 0; t < 3; t++) begin
      n_cmp++;
      if (cap_v[t] !== 1'b1 || cap_a[t] !== m2_a[t] || cap_b[t] !== m2_b[t]) begin
        n_bad++;
        $display("FAIL rst_replay_t%0d: v=%b a=%h b=%h, required 1 %h %h",
                 t, cap_v[t], cap_a[t], cap_b[t], m2_a[t], m2_b[t]);
      end
    end
  endtask

  task automatic test_negative;
    logic [LW-1:0] ea [3];
    logic [LW-1:0] eb [3];
    ea = '{32'h0000_8000, 32'h8000_8000, 32'h8000_0000};
    eb = '{32'h0000_7FFF, 32'h7FFF_7FFF, 32'h7FFF_0000};
    do_reset;
    drive(1'b1, 32'h8000_8000, 32'h7FFF_7FFF);
    tick;
    tick;
    drive(1'b0, '0, '0);
    capture;
    for (int t = 0; t < 3; t++) begin
      n_cmp++;
      if (cap_a[t] !== ea[t] || cap_b[t] !== eb[t]) begin
        n_bad++;
        $display("FAIL neg_t%0d: a=%h b=%h, required %h %h", t, cap_a[t], cap_b[t], ea[t], eb[t]);
      end
    end
  endtask

  // Streams M1 then M2 with s_valid held high; a beat advances only on handshake.
  task automatic test_back_to_back;
    logic [LW-1:0] ra [4];
    logic [LW-1:0] cb [4];
    logic [LW-1:0] a_h [17];
    logic [LW-1:0] b_h [17];
    logic [16:0]   v_h, v_exp;
    int            acc_c [4];
    int            acc_exp [4];
    int            idx, f1, f2;
    logic          acc;
    ra = '{32'h0002_0001, 32'h0004_0003, 32'h000A_0009, 32'h000C_000B};
    cb = '{32'h0007_0005, 32'h0008_0006, 32'h000F_000D, 32'h0010_000E};
`ifdef SYSTOLIC_FEEDER_DBUF_EN
    v_exp   = 17'h00E1C;
    acc_exp = '{1, 2, 3, 4};
    f2      = 9;
`else
    v_exp   = 17'h0381C;
    acc_exp = '{1, 2, 10, 11};
    f2      = 11;
`endif
    f1  = 2;
    idx = 0;
    v_h = '0;
    acc_c = '{0, 0, 0, 0};
    do_reset;
    for (int c = 1; c <= 16; c++) begin
      if (idx < 4) drive(1'b1, ra[idx], cb[idx]);
      else         drive(1'b0, '0, '0);
      acc = sif.s_valid && sif.s_ready;
      tick;
      if (acc) begin
        acc_c[idx] = c;
        idx++;
      end
      v_h[c] = arr_valid;
      a_h[c] = arr_a;
      b_h[c] = arr_b;
    end
    drive(1'b0, '0, '0);
    n_cmp++;
    if (idx != 4) begin
      n_bad++;
      $display("FAIL b2b_beats: accepted %0d, required 4", idx);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (acc_c[k] != acc_exp[k]) begin
        n_bad++;
        $display("FAIL b2b_accept%0d: cycle %0d, required %0d", k, acc_c[k], acc_exp[k]);
      end
    end
    n_cmp++;
    if (v_h !== v_exp) begin
      n_bad++;
      $display("FAIL b2b_valid_map: got %h, required %h", v_h, v_exp);
    end
    for (int t = 0; t < 3; t++) begin
      n_cmp++;
      if (a_h[f1+t] !== m1_a[t] || b_h[f1+t] !== m1_b[t]) begin
        n_bad++;
        $display("FAIL b2b_m1_t%0d: a=%h b=%h, required %h %h", t, a_h[f1+t], b_h[f1+t], m1_a[t], m1_b[t]);
      end
      n_cmp++;
      if (a_h[f2+t] !== m2_a[t] || b_h[f2+t] !== m2_b[t]) begin
        n_bad++;
        $display("FAIL b2b_m2_t%0d: a=%h b=%h, required %h %h", t, a_h[f2+t], b_h[f2+t], m2_a[t], m2_b[t]);
      end
    end
  endtask

  initial begin
    drive(1'b0, '0, '0);
    test_reset;
    test_basic_feed;
    test_handshake;
    test_reset_midfeed;
    test_negative;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream stage of `systolic_array`; drives its `valid_in`, `matrix_a_in` and `matrix_b_in`.
- Accepts an N×N A matrix (row per beat) and B matrix (column per beat) over a valid/ready stream and stores them in register banks.
- Replays them as the diagonal skewed wavefront the array needs: lane i delayed i cycles.
- Then holds the array idle for a drain window while the array unloads its results.

Parameters:
- DATAWIDTH, 16, element width (signed).
- N_SIZE, 5, matrix dimension; legal range 2..8.
- DRAIN_CYCLES, N_SIZE+2, idle cycles after the feed, before the next load or feed.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  feeder can accept a beat.
- s_row_a  in  N_SIZE*DATAWIDTH  row k of A; element m in bits [m*DW +: DW].
- s_col_b  in  N_SIZE*DATAWIDTH  column k of B; element m in bits [m*DW +: DW].
- arr_valid  out  1  goes to array `valid_in`.
- arr_a  out  N_SIZE*DATAWIDTH  skewed A lanes; lane i feeds array row i.
- arr_b  out  N_SIZE*DATAWIDTH  skewed B lanes; lane j feeds array column j.
- busy  out  1  high in FEED or DRAIN.

Behaviour:
- Reset (asynchronous, any state, including mid-FEED):
  - state=LOAD, all counters 0, banks cleared to 0.
  - s_ready=1, arr_valid=0, arr_a=0, arr_b=0, busy=0.
  - A partially loaded or partially fed matrix is discarded.
- Handshake: a beat transfers when s_valid&&s_ready. s_valid may be held with no transfer while s_ready=0; the data is not sampled.
- LOAD:
  - s_ready=1.
  - Beat k (0..N-1) writes A[k][*] ← s_row_a and B[*][k] ← s_col_b; beat counter increments.
  - On beat N-1: next state FEED, feed counter t=0.
- FEED: lasts exactly 2N-1 cycles; s_ready=0, busy=1. Outputs are registered:
  - arr_valid=1 throughout.
  - lane i of arr_a = A[i][t-i] when 0 ≤ t-i < N, else 0.
  - lane j of arr_b = B[t-j][j] when 0 ≤ t-j < N, else 0.
  - First FEED output appears the cycle after the last accepted beat (latency 1).
  - When t = 2N-2: next state DRAIN, drain counter d=0.
- DRAIN:
  - arr_valid=0, arr_a=arr_b=0, s_ready=0, busy=1.
  - After DRAIN_CYCLES cycles: return to LOAD, beat counter reset.
- arr_a and arr_b are 0 whenever arr_valid=0.
- Counters: t is sized $clog2(2*N_SIZE); d is sized $clog2(DRAIN_CYCLES+1). No wrap inside a phase; terminal-count compares use ==.
- Data passes through unmodified: no arithmetic, signedness preserved.
- Boundary: s_valid held continuously across the LOAD→FEED edge. The beat after beat N-1 is not accepted (s_ready is already 0 that cycle); it is accepted on the first LOAD cycle after DRAIN.

Optional Feature:
- Macro: SYSTOLIC_FEEDER_DBUF_EN.
- Defined:
  - Two A/B bank pairs (ping/pong).
  - s_ready=1 in FEED and DRAIN if the idle bank is not yet full, so the next matrix loads while the current one feeds.
  - On DRAIN completion with the idle bank full: swap banks and enter FEED directly (no LOAD cycle). If it is not full: go to LOAD on the partially filled bank.
  - Reset clears both banks and selects bank 0.
- Undefined: single bank; behaviour exactly as above.

Decomposition:
- Package `systolic_pkg`:
  - feeder_state_e enum {LOAD, FEED, DRAIN}.
  - default DATAWIDTH and N_SIZE localparams.
  - Function lane_sel(t, lane) returning the index plus an in-range flag.
- Sub-module `systolic_feeder_bank`: holds one N×N A bank and one N×N B bank, with write port (beat index, row, col) and combinational skew read (t).
- Top holds the FSM and counters. The double-buffer build instantiates the bank twice.

Test Plan:
1. N=2, DW=16, A=[[1,2],[3,4]], B=[[5,6],[7,8]]; beats (row a=[1,2], col b=[5,7]) and ([3,4],[6,8]). Check FEED cycles:
   - arr_a lanes {a0,a1} = {1,0},{2,3},{0,4}.
   - arr_b lanes {b0,b1} = {5,0},{7,6},{0,8}.
   - arr_valid high for exactly 3 cycles; array downstream yields C=[[19,22],[43,50]].
2. s_valid toggling 1/0 during LOAD (N=5): only handshaked beats are stored; FEED starts 1 cycle after the 5th accepted beat; s_ready=0 for 9+DRAIN_CYCLES cycles.
3. Assert rst at FEED t=3: all outputs are 0 on the same cycle (async); after release s_ready=1 and a fresh load replays correctly.
4. Negative values: A entries -32768 and B entries 32767 appear bit-exact on the lanes.
5. Back-to-back matrices with s_valid held high: second FEED begins 1 cycle after the last beat of the second load; no beat is lost or duplicated.
6. With SYSTOLIC_FEEDER_DBUF_EN: second matrix loaded during FEED/DRAIN; FEED of matrix 2 begins the cycle after DRAIN ends (gap between feeds = DRAIN_CYCLES exactly).
